reg_file_arbiter: RTL

Arbiter and sequencer in front of the single-write-port, single-read-port register file. It shares the file between two write requesters and two read requesters with independent round-robin arbitration, and returns read data through a registered response. The file itself has no reset, so after reset the block first sweeps every location to zero and only then serves requesters. It sits between the requesting datapath blocks and the register file; no other block drives the file's ports.

---
 rtl/reg_file_arbiter_pkg.sv | 40 ++++
 rtl/reg_file_arbiter_rr_arbiter2.sv | 43 ++++
 rtl/reg_file_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_arbiter_pkg
//
// Shared definitions for the register-file arbiter slice.
//
// Contents:
//    state_t   - sequencer state encoding (INIT sweep, RUN service)
//    NUM_REQ   - number of requesters on each side (write and read)
//    rr_pick   - two-requester round-robin grant rule, shared by every
//                arbiter instance so both sides behave identically
// ---------------------------------------------------------------------------
package reg_file_arbiter_pkg;

   // INIT clears the file after reset; RUN serves the requesters.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Each side (write and read) is shared by this many requesters.
   localparam int NUM_REQ = 2;

   // Round-robin grant for two requesters.
   // A lone request always wins. When both requesters ask, the pointer
   // names the winner: ptr=0 favours requester 0, ptr=1 favours requester 1.
   // The result is one-hot or zero.
   function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic               ptr);
      logic [NUM_REQ-1:0] gnt;
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = '0;
      endcase
      return gnt;
   endfunction

endpackage

// File: rtl/reg_file_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//
// Two-requester round-robin arbiter with its own priority pointer flop.
// The grant is purely combinational from req and the pointer. The pointer
// flips only when both requesters asked in the same cycle and update_en is
// high, so a lone requester never steals the other's next turn.
//
// Ports:
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset (pointer -> requester 0)
//    req        in   request vector, one bit per requester
//    update_en  in   allows the pointer to advance this cycle
//    gnt        out  one-hot or zero grant
// ---------------------------------------------------------------------------
module rr_arbiter2
   import reg_file_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               update_en,
   output logic [NUM_REQ-1:0] gnt
);

   logic ptr;

   // Grant follows the shared round-robin rule with the current pointer.
   always_comb begin
      gnt = rr_pick(req, ptr);
   end

   // The pointer only moves on a real contention so that the loser of a
   // tie is guaranteed to win the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (update_en && (req == 2'b11)) begin
         ptr <= ~ptr;
      end
   end

endmodule

// File: rtl/reg_file_arbiter.sv
// ---------------------------------------------------------------------------
// reg_file_arbiter
//
// Arbiter and sequencer in front of a single-write-port, single-read-port
// register file of 2**N words of BITS bits. The file has no reset of its
// own, so after reset this block first sweeps every location to zero
// (busy high) and only then serves two write requesters and two read
// requesters, each side with an independent round-robin arbiter.
// Read data comes back through a registered response one cycle after the
// grant, tagged by a one-hot rvalid naming the owner.
//
// Ports:
//    CLK, RST_N             clock, asynchronous active-low reset
//    wreq[1:0]              write requests, held until granted
//    waddr0/1, wdata0/1     per-requester write address and data
//    wgnt[1:0]              write grant, one-hot or zero
//    rreq[1:0]              read requests, held until granted
//    raddr0/1               per-requester read address
//    rgnt[1:0]              read grant, one-hot or zero
//    rdata                  registered read data
//    rvalid[1:0]            one-hot owner of rdata, valid for one cycle
//    busy                   high while the init sweep runs
//    rf_address_w, rf_WE,   register file write port
//    rf_data_w
//    rf_address_r           register file read address
//    rf_data_r              register file read data (combinational in
//                           rf_address_r)
// ---------------------------------------------------------------------------
module reg_file_arbiter
   import reg_file_arbiter_pkg::*;
#(
   parameter int N    = 2,
   parameter int BITS = 4
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_REQ-1:0] wreq,
   input  logic [N-1:0]       waddr0,
   input  logic [N-1:0]       waddr1,
   input  logic [BITS-1:0]    wdata0,
   input  logic [BITS-1:0]    wdata1,
   output logic [NUM_REQ-1:0] wgnt,
   input  logic [NUM_REQ-1:0] rreq,
   input  logic [N-1:0]       raddr0,
   input  logic [N-1:0]       raddr1,
   output logic [NUM_REQ-1:0] rgnt,
   output logic [BITS-1:0]    rdata,
   output logic [NUM_REQ-1:0] rvalid,
   output logic               busy,
   output logic [N-1:0]       rf_address_w,
   output logic               rf_WE,
   output logic [BITS-1:0]    rf_data_w,
   output logic [N-1:0]       rf_address_r,
   input  logic [BITS-1:0]    rf_data_r
);

   state_t             state;
   state_t             state_next;
   logic [N-1:0]       sweep_cnt;
   logic               run;
   logic [NUM_REQ-1:0] wreq_live;
   logic [NUM_REQ-1:0] rreq_live;

   // Requests raised during the sweep are hidden from the arbiters rather
   // than dropped: the requester keeps holding them and they are seen in
   // the first RUN cycle. Hiding them also keeps the pointers frozen.
   assign run       = (state == RUN);
   assign wreq_live = wreq & {NUM_REQ{run}};
   assign rreq_live = rreq & {NUM_REQ{run}};

   // Write-side and read-side arbiters are fully independent, so a write
   // and a read may be granted in the same cycle.
   rr_arbiter2 u_write_arb (
      .clk       (CLK),
      .rst_n     (RST_N),
      .req       (wreq_live),
      .update_en (run),
      .gnt       (wgnt)
   );

   rr_arbiter2 u_read_arb (
      .clk       (CLK),
      .rst_n     (RST_N),
      .req       (rreq_live),
      .update_en (run),
      .gnt       (rgnt)
   );

   // Sequencer state register. Reset always returns to INIT so that a
   // reset in the middle of operation restarts the zero sweep.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= INIT;
      end else begin
         state <= state_next;
      end
   end

   // Sweep counter walks every address once during INIT. It wraps back to
   // zero naturally on the last address, which is also the cycle where
   // the sequencer leaves INIT, and then rests at zero during RUN.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sweep_cnt <= '0;
      end else if (state == INIT) begin
         sweep_cnt <= sweep_cnt + 1'b1;
      end else begin
         sweep_cnt <= '0;
      end
   end

   // Next-state logic and the write-port mux. During INIT the write port
   // is owned by the sweep (zero data at the counter address); during RUN
   // it carries the granted requester's address and data, and is driven
   // to all zeros with the enable low when nobody is granted.
   always_comb begin
      state_next   = state;
      busy         = 1'b0;
      rf_WE        = 1'b0;
      rf_address_w = '0;
      rf_data_w    = '0;
      case (state)
         INIT: begin
            busy         = 1'b1;
            rf_WE        = 1'b1;
            rf_address_w = sweep_cnt;
            rf_data_w    = '0;
            if (sweep_cnt == {N{1'b1}}) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (wgnt[0]) begin
               rf_WE        = 1'b1;
               rf_address_w = waddr0;
               rf_data_w    = wdata0;
            end else if (wgnt[1]) begin
               rf_WE        = 1'b1;
               rf_address_w = waddr1;
               rf_data_w    = wdata1;
            end
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   // Read-address mux. The file reads combinationally, so the granted
   // address must be on rf_address_r during the grant cycle; idle is zero.
   always_comb begin
      rf_address_r = '0;
      if (rgnt[0]) begin
         rf_address_r = raddr0;
      end else if (rgnt[1]) begin
         rf_address_r = raddr1;
      end
   end

   // Registered read response. Data is captured at the grant edge, which
   // is the same edge that commits any concurrent write, so a same-address
   // write and read in one cycle returns the old contents. rdata holds its
   // last value between reads, while rvalid is a single-cycle tag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdata  <= '0;
         rvalid <= '0;
      end else if (rgnt != '0) begin
         rdata  <= rf_data_r;
         rvalid <= rgnt;
      end else begin
         rvalid <= '0;
      end
   end

endmodule
